// File: rtl/spi_reg_if_pkg.sv
// Shared definitions for the SPI register interface: header layout, FSM state
// encoding and default bank geometry.
package spi_reg_if_pkg;

    // Header is always one byte, MSB first; bit 7 selects read (1) or write (0).
    localparam int unsigned HdrLen = 8;
    localparam int unsigned RwBit  = 7;

    // Default register bank geometry.
    localparam int unsigned NRegDefault = 8;
    localparam int unsigned AwDefault   = 3;
    localparam int unsigned DwDefault   = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StData = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/spi_reg_if_if.sv
// Bus bundle between the synchronized SPI pins / DDS datapath and spi_reg_if.
//   sclk_s, cs_n_s, mosi_s : synchronized SPI inputs (cs_n_s active-low)
//   miso                   : serial read data, 0 when not selected
//   regs                   : flattened register bank, register k at [k*DW +: DW]
//   wr_stb, wr_addr        : one-cycle commit strobe and address of last write
interface spi_reg_if_if
    import spi_reg_if_pkg::*;
#(
    parameter int unsigned NREG = NRegDefault,
    parameter int unsigned AW   = AwDefault,
    parameter int unsigned DW   = DwDefault
) ();

    logic                 sclk_s;
    logic                 cs_n_s;
    logic                 mosi_s;
    logic                 miso;
    logic [NREG*DW-1:0]   regs;
    logic                 wr_stb;
    logic [AW-1:0]        wr_addr;

    modport slave (
        input  sclk_s,
        input  cs_n_s,
        input  mosi_s,
        output miso,
        output regs,
        output wr_stb,
        output wr_addr
    );

    modport master (
        output sclk_s,
        output cs_n_s,
        output mosi_s,
        input  miso,
        input  regs,
        input  wr_stb,
        input  wr_addr
    );

endinterface

// File: rtl/spi_reg_if_edge_det.sv
// edge_det: 1-bit edge detector. Holds the previous sample of sig_i and flags
// the first cycle in which the input differs from it.
//   clk, rst_n : clock, synchronous active-low reset
//   sig_i      : input to watch
//   rise_o     : sig_i is 1 and previous sample was 0
//   fall_o     : sig_i is 0 and previous sample was 1
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/spi_reg_if.sv
// spi_reg_if: SPI mode-0 slave that decodes header+data frames and maintains a
// bank of NREG configuration registers of DW bits each.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : slave side of spi_reg_if_if (SPI pins, MISO, register bus,
//                write strobe and address)
module spi_reg_if
    import spi_reg_if_pkg::*;
#(
    parameter int unsigned NREG = NRegDefault,
    parameter int unsigned AW   = AwDefault,
    parameter int unsigned DW   = DwDefault
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_reg_if_if.slave    bus
);

    localparam int unsigned CntMax = (DW > HdrLen) ? DW : HdrLen;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    logic rise, fall;

    edge_det u_sclk_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (bus.sclk_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [HdrLen-2:0]    hdr_q;
    logic [DW-1:0]        data_q;
    logic [DW-1:0]        shout_q;
    logic                 rd_q;
    logic                 addr_ok_q;
    logic [AW-1:0]        addr_q;
    logic                 armed_q;
    logic                 miso_q;
    logic                 wr_stb_q;
    logic [AW-1:0]        wr_addr_q;
    logic [NREG*DW-1:0]   regs_q;

    // Header/data words including the bit being sampled this cycle.
    logic [HdrLen-1:0]    hdr_full;
    logic [AW-1:0]        hdr_addr;
    logic                 hdr_addr_ok;
    logic [DW-1:0]        rd_word;
    logic [DW-1:0]        data_full;
    logic                 unused_hdr;

    always_comb begin
        hdr_full    = {hdr_q, bus.mosi_s};
        hdr_addr    = hdr_full[AW-1:0];
        data_full   = (data_q << 1) | DW'(bus.mosi_s);
        hdr_addr_ok = 1'b0;
        rd_word     = '0;
        // Out-of-range addresses decode to nothing, so reads return 0.
        for (int k = 0; k < int'(NREG); k++) begin
            if (hdr_addr == AW'(k)) begin
                hdr_addr_ok = 1'b1;
                rd_word     = regs_q[k*DW +: DW];
            end
        end
        unused_hdr = ^hdr_full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hdr_q     <= '0;
            data_q    <= '0;
            shout_q   <= '0;
            rd_q      <= 1'b0;
            addr_ok_q <= 1'b0;
            addr_q    <= '0;
            armed_q   <= 1'b0;
            miso_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            regs_q    <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            if (bus.cs_n_s) begin
                // Deselect wins over any SCLK edge in the same cycle.
                state_q <= StIdle;
                cnt_q   <= '0;
                miso_q  <= 1'b0;
                armed_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // A frame already in flight at reset release is skipped
                        // until chip select has been seen high.
                        if (armed_q) begin
                            state_q <= StHdr;
                            cnt_q   <= '0;
                        end
                    end
                    StHdr: begin
                        if (rise) begin
                            hdr_q <= hdr_full[HdrLen-2:0];
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CntW'(HdrLen - 1)) begin
                                rd_q      <= hdr_full[RwBit];
                                addr_q    <= hdr_addr;
                                addr_ok_q <= hdr_addr_ok;
                                shout_q   <= hdr_full[RwBit] ? rd_word : '0;
                                data_q    <= '0;
                                cnt_q     <= '0;
                                state_q   <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (fall) begin
                            miso_q  <= shout_q[DW-1];
                            shout_q <= shout_q << 1;
                        end
                        if (rise) begin
                            data_q <= data_full;
                            cnt_q  <= cnt_q + 1'b1;
                            if (cnt_q == CntW'(DW - 1)) begin
                                if (!rd_q && addr_ok_q) begin
                                    for (int k = 0; k < int'(NREG); k++) begin
                                        if (addr_q == AW'(k)) begin
                                            regs_q[k*DW +: DW] <= data_full;
                                        end
                                    end
                                    wr_addr_q <= addr_q;
                                    wr_stb_q  <= 1'b1;
                                end
                                miso_q  <= 1'b0;
                                state_q <= StDone;
                            end
                        end
                    end
                    StDone: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.miso    = miso_q;
    assign bus.regs    = regs_q;
    assign bus.wr_stb  = wr_stb_q;
    assign bus.wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_if.sv
// Bench for spi_reg_if: two instances (NREG=8 and NREG=6) share the same SPI
// pins, and an array-based register model predicts contents, strobes and reads.
module tb_spi_reg_if;
    import spi_reg_if_pkg::*;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, cs_n, mosi;

    int checks = 0;
    int errors = 0;
    int stb8 = 0, stb6 = 0;
    int exp_stb8 = 0, exp_stb6 = 0;
    logic [AW-1:0] exp_addr8, exp_addr6;
    logic [7:0] m8 [8];
    logic [7:0] m6 [6];

    always #5 clk = ~clk;

    spi_reg_if_if #(.NREG(8), .AW(AW), .DW(DW)) bus8 ();
    spi_reg_if_if #(.NREG(6), .AW(AW), .DW(DW)) bus6 ();

    assign bus8.sclk_s = sclk;
    assign bus8.cs_n_s = cs_n;
    assign bus8.mosi_s = mosi;
    assign bus6.sclk_s = sclk;
    assign bus6.cs_n_s = cs_n;
    assign bus6.mosi_s = mosi;

    spi_reg_if #(.NREG(8), .AW(AW), .DW(DW)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    spi_reg_if #(.NREG(6), .AW(AW), .DW(DW)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    // Count strobe-high cycles; a stretched strobe shows up as an extra count.
    always @(negedge clk) begin
        if (bus8.wr_stb === 1'b1) stb8++;
        if (bus6.wr_stb === 1'b1) stb6++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) m8[k] = 8'h00;
        for (int k = 0; k < 6; k++) m6[k] = 8'h00;
        exp_addr8 = '0;
        exp_addr6 = '0;
    endfunction

    // Apply a frame to the model; only complete write frames have an effect.
    function automatic void model_frame(input logic [7:0] hdr, input logic [7:0] data,
                                        input bit complete);
        int a;
        a = int'(hdr[2:0]);
        if (complete && !hdr[7]) begin
            m8[a] = data;
            exp_addr8 = hdr[2:0];
            exp_stb8++;
            if (a < 6) begin
                m6[a] = data;
                exp_addr6 = hdr[2:0];
                exp_stb6++;
            end
        end
    endfunction

    function automatic logic [63:0] flat8();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = m8[k];
        return r;
    endfunction

    function automatic logic [47:0] flat6();
        logic [47:0] r;
        for (int k = 0; k < 6; k++) r[k*8 +: 8] = m6[k];
        return r;
    endfunction

    function automatic logic [7:0] exp_rd8(input logic [7:0] hdr);
        return m8[int'(hdr[2:0])];
    endfunction

    function automatic logic [7:0] exp_rd6(input logic [7:0] hdr);
        return (int'(hdr[2:0]) < 6) ? m6[int'(hdr[2:0])] : 8'h00;
    endfunction

    // Master side of one frame, SCLK = clk/8. ndata data bits are clocked
    // before deselect; with cs_with_rise the last rise coincides with CS_N
    // going high. rst_at pulses rst_n for one cycle before bit index rst_at.
    task automatic spi_frame(input logic [7:0] hdr, input logic [7:0] data,
                             input int ndata, input bit cs_with_rise, input int rst_at,
                             output logic [7:0] rd8, output logic [7:0] rd6);
        logic [15:0] word;
        bit deselected;
        word = {hdr, data};
        rd8 = 8'h00;
        rd6 = 8'h00;
        deselected = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 8 + ndata; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            mosi = word[15-i];
            tick(4);
            if (i >= 8) begin
                rd8 = {rd8[6:0], bus8.miso};
                rd6 = {rd6[6:0], bus6.miso};
            end
            sclk = 1'b1;
            if (cs_with_rise && i == 8 + ndata - 1) begin
                cs_n = 1'b1;
                deselected = 1'b1;
            end
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
        if (!deselected) cs_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(2);
        checks++;
        if (bus8.regs !== 64'h0) begin
            errors++;
            $display("FAIL reset_regs8: got %h expected %h", bus8.regs, 64'h0);
        end
        checks++;
        if (bus8.miso !== 1'b0 || bus6.miso !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso: got %b/%b expected 0/0", bus8.miso, bus6.miso);
        end
        checks++;
        if (bus8.wr_addr !== 3'd0 || bus8.wr_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr: got addr %0d stb %b expected 0 0", bus8.wr_addr,
                     bus8.wr_stb);
        end
        rst_n = 1'b1;
        model_reset();
        stb8 = 0;
        stb6 = 0;
        tick(20);
        checks++;
        if (stb8 != 0 || stb6 != 0 || bus6.regs !== 48'h0) begin
            errors++;
            $display("FAIL idle: got stb %0d/%0d regs6 %h expected 0/0 0", stb8, stb6,
                     bus6.regs);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] r8, r6;
        spi_frame(8'h03, 8'hA5, 8, 1'b0, -1, r8, r6);
        model_frame(8'h03, 8'hA5, 1'b1);
        checks++;
        if (bus8.regs !== flat8() || bus6.regs !== flat6()) begin
            errors++;
            $display("FAIL write_regs: got %h/%h expected %h/%h", bus8.regs, bus6.regs,
                     flat8(), flat6());
        end
        checks++;
        if (stb8 != exp_stb8 || bus8.wr_addr !== 3'd3) begin
            errors++;
            $display("FAIL write_stb: got %0d addr %0d expected %0d addr 3", stb8,
                     bus8.wr_addr, exp_stb8);
        end
        spi_frame(8'h83, 8'h00, 8, 1'b0, -1, r8, r6);
        checks++;
        if (r8 !== 8'hA5 || r6 !== 8'hA5) begin
            errors++;
            $display("FAIL read_miso: got %h/%h expected a5/a5", r8, r6);
        end
        checks++;
        if (bus8.regs !== flat8() || stb8 != exp_stb8 || stb6 != exp_stb6) begin
            errors++;
            $display("FAIL read_side_effect: got %h stb %0d expected %h stb %0d",
                     bus8.regs, stb8, flat8(), exp_stb8);
        end
    endtask

    task automatic test_abort();
        logic [7:0] r8, r6;
        spi_frame(8'h05, 8'h5A, 4, 1'b0, -1, r8, r6);
        checks++;
        if (bus8.regs !== flat8() || stb8 != exp_stb8 || stb6 != exp_stb6) begin
            errors++;
            $display("FAIL abort: got %h stb %0d expected %h stb %0d", bus8.regs, stb8,
                     flat8(), exp_stb8);
        end
        // Deselect in the same cycle as the final rise must also abort.
        spi_frame(8'h02, 8'h7E, 8, 1'b1, -1, r8, r6);
        checks++;
        if (bus8.regs !== flat8() || stb8 != exp_stb8) begin
            errors++;
            $display("FAIL abort_on_rise: got %h stb %0d expected %h stb %0d", bus8.regs,
                     stb8, flat8(), exp_stb8);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] r8, r6;
        spi_frame(8'h07, 8'hFF, 8, 1'b0, -1, r8, r6);
        model_frame(8'h07, 8'hFF, 1'b1);
        checks++;
        if (bus6.regs !== flat6() || stb6 != exp_stb6) begin
            errors++;
            $display("FAIL oor_write6: got %h stb %0d expected %h stb %0d", bus6.regs, stb6,
                     flat6(), exp_stb6);
        end
        checks++;
        if (bus8.regs !== flat8() || stb8 != exp_stb8 || bus8.wr_addr !== 3'd7) begin
            errors++;
            $display("FAIL oor_write8: got %h stb %0d expected %h stb %0d", bus8.regs, stb8,
                     flat8(), exp_stb8);
        end
        spi_frame(8'h87, 8'h00, 8, 1'b0, -1, r8, r6);
        checks++;
        if (r6 !== 8'h00 || r8 !== 8'hFF) begin
            errors++;
            $display("FAIL oor_read: got %h/%h expected ff/00", r8, r6);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r8, r6;
        spi_frame(8'h01, 8'h3C, 8, 1'b0, -1, r8, r6);
        model_frame(8'h01, 8'h3C, 1'b1);
        checks++;
        if (bus8.regs !== flat8()) begin
            errors++;
            $display("FAIL pre_reset_write: got %h expected %h", bus8.regs, flat8());
        end
        // Reset three bits into the data phase; the rest of the frame is ignored.
        spi_frame(8'h01, 8'h77, 8, 1'b0, 11, r8, r6);
        model_reset();
        checks++;
        if (bus8.regs !== flat8() || bus6.regs !== flat6() || bus8.wr_addr !== 3'd0
            || stb8 != exp_stb8 || stb6 != exp_stb6) begin
            errors++;
            $display("FAIL mid_reset: got %h addr %0d stb %0d expected %h addr 0 stb %0d",
                     bus8.regs, bus8.wr_addr, stb8, flat8(), exp_stb8);
        end
        spi_frame(8'h01, 8'h11, 8, 1'b0, -1, r8, r6);
        model_frame(8'h01, 8'h11, 1'b1);
        checks++;
        if (bus8.regs !== flat8() || bus6.regs !== flat6() || stb8 != exp_stb8) begin
            errors++;
            $display("FAIL post_reset_write: got %h stb %0d expected %h stb %0d", bus8.regs,
                     stb8, flat8(), exp_stb8);
        end
    endtask

    task automatic test_random();
        logic [7:0] hdr, data, r8, r6;
        int mode, ndata;
        bit cwr, complete;
        for (int n = 0; n < 40; n++) begin
            hdr  = 8'($urandom);
            data = 8'($urandom);
            mode = int'($urandom_range(0, 5));
            ndata = (mode == 0) ? int'($urandom_range(0, 7)) : 8;
            cwr = (mode == 1);
            complete = (ndata == 8) && !cwr;
            spi_frame(hdr, data, ndata, cwr, -1, r8, r6);
            if (ndata == 8 && hdr[7]) begin
                checks++;
                if (r8 !== exp_rd8(hdr) || r6 !== exp_rd6(hdr)) begin
                    errors++;
                    $display("FAIL rand_read[%0d] hdr %h: got %h/%h expected %h/%h", n, hdr,
                             r8, r6, exp_rd8(hdr), exp_rd6(hdr));
                end
            end
            model_frame(hdr, data, complete);
            checks++;
            if (bus8.regs !== flat8() || bus6.regs !== flat6()) begin
                errors++;
                $display("FAIL rand_regs[%0d] hdr %h: got %h/%h expected %h/%h", n, hdr,
                         bus8.regs, bus6.regs, flat8(), flat6());
            end
            checks++;
            if (stb8 != exp_stb8 || stb6 != exp_stb6 || bus8.wr_addr !== exp_addr8
                || bus6.wr_addr !== exp_addr6) begin
                errors++;
                $display("FAIL rand_stb[%0d]: got %0d/%0d addr %0d/%0d expected %0d/%0d addr %0d/%0d",
                         n, stb8, stb6, bus8.wr_addr, bus6.wr_addr, exp_stb8, exp_stb6,
                         exp_addr8, exp_addr6);
            end
            tick(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        tick(3);
        test_reset();
        test_write_read();
        test_abort();
        test_out_of_range();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
